// File: rtl/regfile_pkg.sv
// Shared constants and the read-port result type for the picoMips register file.
package regfile_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_NUM_REGS = 4;
   // Result struct carries the widest supported word; ports use the low WIDTH bits.
   localparam int RF_MAX_WIDTH = 64;

   typedef struct packed {
      logic [RF_MAX_WIDTH-1:0] data;
      logic                    pending;
   } rd_port_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, zero-register mask, write-first bypass.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [AW-1:0]                  rd_addr,
   input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
   input  logic [NUM_REGS-1:0]            pend_nxt,
   input  logic                           wr_ok,
   input  logic [AW-1:0]                  wr_addr,
   input  logic [WIDTH-1:0]               wr_data,
   output rd_port_t                       rd_q
);

   localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

   rd_port_t rd_d;
   logic     addr_ok;

   always_comb begin
      addr_ok = ({1'b0, rd_addr} < NREGS) && !((ZERO_REG != 0) && (rd_addr == '0));
      rd_d    = '0;
      if (addr_ok) begin
         rd_d.data = RF_MAX_WIDTH'(regs[rd_addr]);
         if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr))
            rd_d.data = RF_MAX_WIDTH'(wr_data);
         // Pending always reflects this edge's write/reserve, independent of BYPASS.
         rd_d.pending = pend_nxt[rd_addr];
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) rd_q <= '0;
      else       rd_q <= rd_d;
   end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised 2R1W register file with per-register pending scoreboard.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [AW-1:0]    RdAddrA,
   input  logic [AW-1:0]    RdAddrB,
   output logic [WIDTH-1:0] RdDataA,
   output logic [WIDTH-1:0] RdDataB,
   output logic             PendingA,
   output logic             PendingB,
   input  logic             Write,
   input  logic [AW-1:0]    WrAddr,
   input  logic [WIDTH-1:0] WrData,
   input  logic             Reserve,
   input  logic [AW-1:0]    ResAddr
);

   localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

   logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]            pend_q, pend_d;
   logic                           wr_ok, res_ok;
   rd_port_t                       rd_a, rd_b;

   always_comb begin
      wr_ok  = Write && ({1'b0, WrAddr} < NREGS) && !((ZERO_REG != 0) && (WrAddr == '0));
      res_ok = Reserve && ({1'b0, ResAddr} < NREGS) && !((ZERO_REG != 0) && (ResAddr == '0));
      regs_d = regs_q;
      pend_d = pend_q;
      if (wr_ok) begin
         regs_d[WrAddr] = WrData;
         pend_d[WrAddr] = 1'b0;
      end
      // Applied after the write so a same-edge reservation marks the new producer.
      if (res_ok) pend_d[ResAddr] = 1'b1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   rf_read_port #(
      .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG), .AW(AW)
   ) u_port_a (
      .Clock(Clock), .Reset(Reset), .rd_addr(RdAddrA), .regs(regs_q), .pend_nxt(pend_d),
      .wr_ok(wr_ok), .wr_addr(WrAddr), .wr_data(WrData), .rd_q(rd_a)
   );

   rf_read_port #(
      .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG), .AW(AW)
   ) u_port_b (
      .Clock(Clock), .Reset(Reset), .rd_addr(RdAddrB), .regs(regs_q), .pend_nxt(pend_d),
      .wr_ok(wr_ok), .wr_addr(WrAddr), .wr_data(WrData), .rd_q(rd_b)
   );

   assign RdDataA  = rd_a.data[WIDTH-1:0];
   assign RdDataB  = rd_b.data[WIDTH-1:0];
   assign PendingA = rd_a.pending;
   assign PendingB = rd_b.pending;

   // Bits above WIDTH are always zero.
   logic unused_hi;
   assign unused_hi = ^{rd_a.data, rd_b.data};

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: four configurations share one stimulus stream.
module tb_reg_file_sb;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [1:0] RdAddrA = '0, RdAddrB = '0, WrAddr = '0, ResAddr = '0;
   logic [7:0] WrData = '0;
   logic       Write = 1'b0, Reserve = 1'b0;

   logic [7:0] da_b1, db_b1, da_b0, db_b0, da_z, db_z, da_n3, db_n3;
   logic       pa_b1, pb_b1, pa_b0, pb_b0, pa_z, pb_z, pa_n3, pb_n3;

   int passed = 0;
   int total  = 0;

   always #5 Clock = ~Clock;

   reg_file_sb #(.WIDTH(8), .NUM_REGS(4), .BYPASS(1), .ZERO_REG(0)) u_b1 (
      .Clock(Clock), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(da_b1), .RdDataB(db_b1), .PendingA(pa_b1), .PendingB(pb_b1),
      .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr));

   reg_file_sb #(.WIDTH(8), .NUM_REGS(4), .BYPASS(0), .ZERO_REG(0)) u_b0 (
      .Clock(Clock), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(da_b0), .RdDataB(db_b0), .PendingA(pa_b0), .PendingB(pb_b0),
      .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr));

   reg_file_sb #(.WIDTH(8), .NUM_REGS(4), .BYPASS(1), .ZERO_REG(1)) u_z (
      .Clock(Clock), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(da_z), .RdDataB(db_z), .PendingA(pa_z), .PendingB(pb_z),
      .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr));

   reg_file_sb #(.WIDTH(8), .NUM_REGS(3), .BYPASS(1), .ZERO_REG(0)) u_n3 (
      .Clock(Clock), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(da_n3), .RdDataB(db_n3), .PendingA(pa_n3), .PendingB(pb_n3),
      .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr));

   typedef struct {
      logic       wr;
      logic [1:0] wa;
      logic [7:0] wd;
      logic       rs;
      logic [1:0] ra;
      logic [1:0] aa;
      logic [1:0] ab;
      logic [7:0] eda;
      logic       epa;
      logic [7:0] edb;
      logic       epb;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic wr, input logic [1:0] wa, input logic [7:0] wd,
                        input logic rs, input logic [1:0] ra,
                        input logic [1:0] aa, input logic [1:0] ab);
      Write = wr; WrAddr = wa; WrData = wd; Reserve = rs; ResAddr = ra;
      RdAddrA = aa; RdAddrB = ab;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   initial begin
      //            wr  wa     wd    rs  ra     aa     ab     eda   epa   edb   epb
      vecs[0]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd3, 8'hA5, 1'b0, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd1, 2'd2, 8'h11, 1'b0, 8'hA5, 1'b0};
      vecs[3]  = '{1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 2'd1, 2'd1, 8'h22, 1'b0, 8'h22, 1'b0};
      vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd1, 8'h00, 1'b1, 8'h22, 1'b0};
      vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd3, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[6]  = '{1'b1, 2'd3, 8'h7F, 1'b0, 2'd0, 2'd3, 2'd2, 8'h7F, 1'b0, 8'hA5, 1'b0};
      vecs[7]  = '{1'b1, 2'd3, 8'h01, 1'b1, 2'd3, 2'd3, 2'd3, 8'h01, 1'b1, 8'h01, 1'b1};
      vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd0, 8'h01, 1'b1, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, 2'd2, 8'h5A, 1'b1, 2'd0, 2'd0, 2'd2, 8'h00, 1'b1, 8'h5A, 1'b0};
      vecs[10] = '{1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd0, 2'd1, 8'hFF, 1'b0, 8'h22, 1'b0};
      vecs[11] = '{1'b1, 2'd1, 8'h33, 1'b1, 2'd1, 2'd1, 2'd3, 8'h33, 1'b1, 8'h01, 1'b1};

      do_reset();
      chk("reset_da", da_b1, 8'h00);
      chk("reset_pa", {7'd0, pa_b1}, 8'h00);
      chk("reset_db", db_b1, 8'h00);
      chk("reset_pb", {7'd0, pb_b1}, 8'h00);

      // Main configuration: write-first, no zero register, depth 4.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].ra, vecs[i].aa, vecs[i].ab);
         step();
         chk($sformatf("vec%0d_da", i), da_b1, vecs[i].eda);
         chk($sformatf("vec%0d_pa", i), {7'd0, pa_b1}, {7'd0, vecs[i].epa});
         chk($sformatf("vec%0d_db", i), db_b1, vecs[i].edb);
         chk($sformatf("vec%0d_pb", i), {7'd0, pb_b1}, {7'd0, vecs[i].epb});
      end

      // Mid-run reset: outputs must drop with no clock edge.
      drive(1'b1, 2'd1, 8'h5A, 1'b1, 2'd2, 2'd1, 2'd2);
      step();
      chk("pre_rst_da", da_b1, 8'h5A);
      chk("pre_rst_pb", {7'd0, pb_b1}, 8'h01);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd2);
      Reset = 1'b1;
      #2;
      chk("async_rst_da", da_b1, 8'h00);
      chk("async_rst_pb", {7'd0, pb_b1}, 8'h00);
      step();
      Reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'(a), 2'(a));
         step();
         chk($sformatf("post_rst_r%0d_da", a), da_b1, 8'h00);
         chk($sformatf("post_rst_r%0d_pa", a), {7'd0, pa_b1}, 8'h00);
         chk($sformatf("post_rst_r%0d_db", a), db_b1, 8'h00);
         chk($sformatf("post_rst_r%0d_pb", a), {7'd0, pb_b1}, 8'h00);
      end

      // Read-first versus write-first on a same-edge hazard.
      do_reset();
      drive(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      drive(1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 2'd1, 2'd1);
      step();
      chk("b0_hazard_da", da_b0, 8'h11);
      chk("b0_hazard_db", db_b0, 8'h11);
      chk("b1_hazard_da", da_b1, 8'h22);
      chk("b1_hazard_db", db_b1, 8'h22);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd1);
      step();
      chk("b0_after_da", da_b0, 8'h22);
      chk("b0_after_db", db_b0, 8'h22);

      // Hardwired zero register.
      do_reset();
      drive(1'b1, 2'd1, 8'h33, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      drive(1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd0, 2'd1);
      step();
      chk("z_r0_da", da_z, 8'h00);
      chk("z_r0_pa", {7'd0, pa_z}, 8'h00);
      chk("z_r1_db", db_z, 8'h33);
      chk("b1_r0_da", da_b1, 8'hFF);
      chk("b1_r0_pa", {7'd0, pa_b1}, 8'h01);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      chk("z_r0_hold_da", da_z, 8'h00);
      chk("z_r0_hold_pb", {7'd0, pb_z}, 8'h00);

      // Depth 3: address 3 is outside the file.
      do_reset();
      drive(1'b1, 2'd0, 8'h10, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      drive(1'b1, 2'd1, 8'h20, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      drive(1'b1, 2'd2, 8'h30, 1'b0, 2'd0, 2'd0, 2'd0);
      step();
      drive(1'b1, 2'd3, 8'hCC, 1'b1, 2'd3, 2'd3, 2'd2);
      step();
      chk("n3_oor_da", da_n3, 8'h00);
      chk("n3_oor_pa", {7'd0, pa_n3}, 8'h00);
      chk("n3_r2_db", db_n3, 8'h30);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd1);
      step();
      chk("n3_r0_da", da_n3, 8'h10);
      chk("n3_r1_db", db_n3, 8'h20);
      chk("n3_r0_pa", {7'd0, pa_n3}, 8'h00);
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd3);
      step();
      chk("n3_r2_da", da_n3, 8'h30);
      chk("n3_r3_db", db_n3, 8'h00);
      chk("n3_r3_pb", {7'd0, pb_n3}, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the picoMips datapath: generic width and depth, two synchronous read ports, one write port.
- Optional write-first bypass and a hardwired-zero register.
- Per-register pending scoreboard so the decoder can detect reads of registers whose result is still in flight.
- Sits between instruction decode and the ALU; replaces the fixed 2 x 8-bit register store.

Parameters:
- WIDTH, 8, data width in bits.
- NUM_REGS, 4, number of architectural registers (>= 2, need not be a power of two).
- BYPASS, 1, 1 = write-first (same-edge write data forwarded to a read), 0 = read-first (old value returned).
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and is never pending.
- AW, $clog2(NUM_REGS), address width (derived, not to be overridden).

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RdAddrA  input  AW  read port A address.
- RdAddrB  input  AW  read port B address.
- RdDataA  output  WIDTH  read port A data, registered.
- RdDataB  output  WIDTH  read port B data, registered.
- PendingA  output  1  register addressed by A has a reservation outstanding, registered.
- PendingB  output  1  same for port B.
- Write  input  1  write enable.
- WrAddr  input  AW  write address.
- WrData  input  WIDTH  write data.
- Reserve  input  1  mark ResAddr as pending (producer issued).
- ResAddr  input  AW  register to reserve.

Behaviour:
- Reset (async assert, sync release by system): all registers 0, all pending bits 0, RdDataA/B = 0, PendingA/B = 0. Reset mid-operation discards in-flight writes and reservations immediately.
- Write: on the rising edge with Write=1 and WrAddr valid, reg[WrAddr] <= WrData; pending[WrAddr] <= 0.
- Reserve: on the rising edge with Reserve=1 and ResAddr valid, pending[ResAddr] <= 1.
- Reserve and Write to the same address on the same edge: data is written and pending ends at 1 (Reserve wins, new producer).
- Read latency is 1 cycle. At edge n, RdDataX <= reg[RdAddrX].
- Read/write same address on the same edge:
  - BYPASS=1: RdDataX <= WrData.
  - BYPASS=0: RdDataX <= old value.
- PendingX at edge n <= pending[RdAddrX] evaluated after that edge's Write/Reserve updates, regardless of BYPASS. A Write clearing the bit shows PendingX=0; a same-edge Reserve shows 1.
- Both ports may read the same address; each returns an identical result.
- ZERO_REG=1, address 0:
  - Write is ignored and Reserve is ignored.
  - Reads return 0 with Pending 0, bypass included.
- Address >= NUM_REGS (non-power-of-two depth):
  - Write and Reserve are ignored.
  - Reads return 0 with Pending 0.
- RdDataX/PendingX update every cycle; there is no read enable.
- Arithmetic: none; data is raw bits, with no sign or width conversion.

Decomposition:
- Shared package regfile_pkg: default WIDTH/NUM_REGS constants and the read-port result struct rd_port_t {data, pending}.
- Natural sub-module: rf_read_port, one instance per read port. It performs the address range check, zero-register masking, bypass mux and output register.
- Storage, the scoreboard vector and write/reserve logic stay in the top level.

Test Plan (WIDTH=8, NUM_REGS=4 unless stated):
- Reset then read: assert Reset mid-run after writing 0x5A to r1; read r0..r3 on both ports -> every RdData=0x00 and Pending=0. Outputs are zero while Reset is high, with no clock edge needed.
- Basic write/read latency: Write r2=0xA5 at edge 1, RdAddrA=2 at edge 2 -> RdDataA=0xA5 after edge 2; RdDataB for r3 stays 0x00.
- Same-edge hazard: r1=0x11, then Write r1=0x22 with RdAddrA=RdAddrB=1 on the same edge:
  - BYPASS=1 -> both ports 0x22.
  - BYPASS=0 -> both ports 0x11, then 0x22 next cycle.
- Scoreboard:
  - Reserve r3 at edge 1 -> PendingA(r3)=1 from edge 2.
  - Write r3=0x7F at edge 4 -> PendingA=0 and RdDataA=0x7F (BYPASS=1) after edge 4.
  - Reserve+Write r3 on one edge -> Pending stays 1.
- ZERO_REG=1: Write r0=0xFF plus Reserve r0 -> RdDataA(r0)=0x00, PendingA=0. Other registers are unaffected.
- Out-of-range, NUM_REGS=3 (AW=2): Write addr 3=0xCC plus Reserve 3 -> no register changes; read addr 3 returns 0x00 and Pending 0.
